axi_lite_excl_mem_slave: RTL and testbench

- AXI4-Lite responder (slave) backing a word-organised RAM; the memory end of the core-side AXI4-Lite master interface.
- Adds an exclusive-access reservation monitor: LR/SC sideband hints give RISC-V load-reserved/store-conditional semantics, with one reservation per master ID.
- Sits behind the interconnect, shared by up to NUM_CORES masters.

---
 rtl/axi_lite_excl_mem_slave.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_axi_lite_excl_mem_slave.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_excl_mem_slave.sv
// AXI4-Lite word-RAM responder with an LR/SC exclusive-access reservation monitor.
// The reservation monitor is built only when AXI_EXCL_MON_EN is defined; otherwise LR is a plain read and SC always fails.
module axi_lite_excl_mem_slave #(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned MASTER_ID_WIDTH = $clog2(NUM_CORES),
  parameter int unsigned DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [31:0]                s_axi_wdata,
  input  logic [3:0]                 s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [31:0]                s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [31:0]                s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [1:0]                 aw_excl_op,
  input  logic [MASTER_ID_WIDTH-1:0] aw_master_id,
  input  logic [1:0]                 ar_excl_op,
  input  logic [MASTER_ID_WIDTH-1:0] ar_master_id
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] ADDR_END = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  OP_LR = 2'b01;
  localparam logic [1:0]  OP_SC = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_e;

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (33'(addr) < ADDR_END);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  w_state_e                   w_state_q, w_state_d;
  logic                       aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0]                aw_addr_q, aw_addr_d;
  logic [1:0]                 aw_op_q, aw_op_d;
  logic [MASTER_ID_WIDTH-1:0] aw_id_q, aw_id_d;
  logic [31:0]                w_data_q, w_data_d;
  logic [3:0]                 w_strb_q, w_strb_d;
  logic                       awready_q, awready_d, wready_q, wready_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;

  r_state_e                   r_state_q, r_state_d;
  logic [31:0]                ar_addr_q, ar_addr_d;
  logic [1:0]                 ar_op_q, ar_op_d;
  logic [MASTER_ID_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [1:0]                 rd_resp_q, rd_resp_d;
  logic                       arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;

  logic                       aw_in_c, ar_in_c;
  logic [IDX_W-1:0]           aw_idx_c, ar_idx_c;
  logic                       mem_we_c, ram_re_c, sc_ok_c, lr_ok_c, lr_set_c;
  logic [31:0]                mem_q [DEPTH];
  logic [31:0]                ram_rd_q;

  assign aw_in_c  = in_range(aw_addr_q);
  assign aw_idx_c = word_idx(aw_addr_q);
  assign ar_in_c  = in_range(ar_addr_q);
  assign ar_idx_c = word_idx(ar_addr_q);

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  // RAM is read-first: a same-edge write is not visible to the read
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) mem_q[aw_idx_c][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
    if (ram_re_c) ram_rd_q <= mem_q[ar_idx_c];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_op_q   <= '0;
      aw_id_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      aw_op_q   <= aw_op_d;
      aw_id_q   <= aw_id_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:   if (aw_held_q && w_held_q) w_state_d = W_COMMIT;
      W_COMMIT: w_state_d = W_RESP;
      W_RESP:   if (bvalid_q && s_axi_bready) w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    aw_op_d   = aw_op_q;
    aw_id_d   = aw_id_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axi_awaddr;
          aw_op_d   = aw_excl_op;
          aw_id_d   = aw_master_id;
        end
        if (s_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb;
        end
      end
      W_COMMIT: begin
        if (!aw_in_c) begin
          bresp_d = RESP_SLVERR;
        end else if (aw_op_q == OP_SC) begin
          mem_we_c = sc_ok_c;
          bresp_d  = sc_ok_c ? RESP_EXOKAY : RESP_OKAY;
        end else begin
          mem_we_c = 1'b1;
          bresp_d  = RESP_OKAY;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: ;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      ar_op_q   <= '0;
      ar_id_q   <= '0;
      rd_resp_q <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      ar_op_q   <= ar_op_d;
      ar_id_q   <= ar_id_d;
      rd_resp_q <= rd_resp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (s_axi_arvalid && arready_q) r_state_d = R_READ;
      R_READ:  r_state_d = R_RESP;
      R_RESP:  if (rvalid_q && s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // R_RESP spends its first cycle moving the RAM output into the response registers
  always_comb begin
    ar_addr_d = ar_addr_q;
    ar_op_d   = ar_op_q;
    ar_id_d   = ar_id_q;
    rd_resp_d = rd_resp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ram_re_c  = 1'b0;
    lr_set_c  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          ar_addr_d = s_axi_araddr;
          ar_op_d   = ar_excl_op;
          ar_id_d   = ar_master_id;
        end
      end
      R_READ: begin
        ram_re_c = ar_in_c;
        if (!ar_in_c) begin
          rd_resp_d = RESP_SLVERR;
        end else if (lr_ok_c) begin
          rd_resp_d = RESP_EXOKAY;
          lr_set_c  = 1'b1;
        end else begin
          rd_resp_d = RESP_OKAY;
        end
      end
      R_RESP: begin
        if (!rvalid_q) begin
          rresp_d = rd_resp_q;
          rdata_d = (rd_resp_q == RESP_SLVERR) ? 32'h0 : ram_rd_q;
        end
      end
      default: ;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_q == R_RESP) && !(rvalid_q && s_axi_rready);
  end

`ifdef AXI_EXCL_MON_EN
  logic [NUM_CORES-1:0] resv_valid_q, resv_valid_d;
  logic [IDX_W-1:0]     resv_word_q [NUM_CORES];
  logic [IDX_W-1:0]     resv_word_d [NUM_CORES];

  function automatic logic id_ok(input logic [MASTER_ID_WIDTH-1:0] id);
    return 32'(id) < NUM_CORES;
  endfunction

  assign sc_ok_c = (aw_op_q == OP_SC) && id_ok(aw_id_q) && resv_valid_q[aw_id_q] &&
                   (resv_word_q[aw_id_q] == aw_idx_c);
  assign lr_ok_c = (ar_op_q == OP_LR) && id_ok(ar_id_q);

  // LR set is applied first so a same-cycle write to that word still clears it
  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_word_d  = resv_word_q;
    if (lr_set_c) begin
      resv_valid_d[ar_id_q] = 1'b1;
      resv_word_d[ar_id_q]  = ar_idx_c;
    end
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (mem_we_c && (resv_word_d[i] == aw_idx_c)) resv_valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resv_valid_q <= '0;
      for (int i = 0; i < int'(NUM_CORES); i++) resv_word_q[i] <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_word_q  <= resv_word_d;
    end
  end
`else
  logic unused_excl;

  assign sc_ok_c     = 1'b0;
  assign lr_ok_c     = 1'b0;
  assign unused_excl = ^{aw_id_q, ar_id_q, ar_op_q, lr_set_c};
`endif

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

endmodule

// File: tb/tb_axi_lite_excl_mem_slave.sv
// Directed self-checking bench for axi_lite_excl_mem_slave; expectations follow the AXI_EXCL_MON_EN build setting.
`timescale 1ns/1ps
module tb_axi_lite_excl_mem_slave;

  localparam int unsigned IDW = 2;
`ifdef AXI_EXCL_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif
  localparam logic [1:0] OP_N  = 2'd0;
  localparam logic [1:0] OP_LR = 2'd1;
  localparam logic [1:0] OP_SC = 2'd2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [31:0]     awaddr, wdata, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     rdata;
  logic [1:0]      aw_op, ar_op;
  logic [IDW-1:0]  aw_id, ar_id;

  int n_cmp = 0;
  int n_mis = 0;

  axi_lite_excl_mem_slave #(.NUM_CORES(4), .DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .aw_excl_op(aw_op), .aw_master_id(aw_id), .ar_excl_op(ar_op), .ar_master_id(ar_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Full write; lat counts edges from the last of AW/W accepted to bvalid seen
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] op, input logic [IDW-1:0] id,
                          output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; lat = 0; resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb; aw_op = op; aw_id = id;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    while (!bvalid && cyc < 40) begin
      @(posedge clk); #1; cyc++; lat++;
    end
    if (!bvalid) begin
      n_cmp++; n_mis++;
      $display("FAIL write_timeout addr=%h: actual no bvalid, required bvalid within 40 cycles", addr);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] op, input logic [IDW-1:0] id,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int cyc;
    cyc = 0; lat = 0; data = 32'hx; resp = 2'b11;
    araddr = addr; ar_op = op; ar_id = id; arvalid = 1'b1;
    while (!arready && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    while (!rvalid && cyc < 40) begin
      @(posedge clk); #1; cyc++; lat++;
    end
    if (!rvalid) begin
      n_cmp++; n_mis++;
      $display("FAIL read_timeout addr=%h: actual no rvalid, required rvalid within 40 cycles", addr);
      return;
    end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    aw_op = 0; aw_id = 0; ar_op = 0; ar_id = 0;
    #3;
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== 41'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: actual aw%b w%b b%b ar%b r%b bresp%b rresp%b rdata%h, required all zero",
               awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_mis++;
      $display("FAIL reset_held: actual readys %b, required 000", {awready, wready, arready});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_mis++;
      $display("FAIL reset_release: actual aw/w/ar/b/r %b, required 11100", {awready, wready, arready, bvalid, rvalid});
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, OP_N, 0, r, lat);
    n_cmp++;
    if (r !== 2'b00 || lat !== 2) begin
      n_mis++;
      $display("FAIL same_cycle_write: actual bresp %b lat %0d, required 00 lat 2", r, lat);
    end
    do_read(32'h10, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 2) begin
      n_mis++;
      $display("FAIL same_cycle_read: actual %h/%b lat %0d, required deadbeef/00 lat 2", d, r, lat);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d; int lat, cyc;
    wdata = 32'h0000AB00; wstrb = 4'b0010; wvalid = 1'b1;
    awaddr = 32'h10; aw_op = OP_N; aw_id = 0;
    cyc = 0;
    while (!wready && cyc < 40) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, wready, bvalid} !== 3'b100) begin
      n_mis++;
      $display("FAIL w_held_readys: actual aw/w/b %b, required 100", {awready, wready, bvalid});
    end
    @(posedge clk); #1;
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 2 || bresp !== 2'b00) begin
      n_mis++;
      $display("FAIL w_first_latency: actual lat %0d bresp %b, required lat 2 bresp 00", lat, bresp);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
        n_mis++;
        $display("FAIL bvalid_hold%0d: actual bvalid %b bresp %b, required 1/00", i, bvalid, bresp);
      end
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      n_mis++;
      $display("FAIL b_release: actual bvalid %b awready %b, required 0/1", bvalid, awready);
    end
    do_read(32'h10, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'hDEADABEF || r !== 2'b00) begin
      n_mis++;
      $display("FAIL strb_merge: actual %h/%b, required deadabef/00", d, r);
    end
  endtask

  task automatic test_lr_sc();
    logic [1:0] r; logic [31:0] d, exp_word; int lat;
    exp_word = MON ? 32'h55 : 32'h11111111;
    do_write(32'h20, 32'h11111111, 4'hF, OP_N, 1, r, lat);
    do_read(32'h20, OP_LR, 1, d, r, lat);
    n_cmp++;
    if (d !== 32'h11111111 || r !== (MON ? 2'b01 : 2'b00)) begin
      n_mis++;
      $display("FAIL lr_resp: actual %h/%b, required 11111111/%b", d, r, MON ? 2'b01 : 2'b00);
    end
    do_write(32'h20, 32'h55, 4'hF, OP_SC, 1, r, lat);
    n_cmp++;
    if (r !== (MON ? 2'b01 : 2'b00)) begin
      n_mis++;
      $display("FAIL sc_first: actual bresp %b, required %b", r, MON ? 2'b01 : 2'b00);
    end
    do_read(32'h20, OP_N, 1, d, r, lat);
    n_cmp++;
    if (d !== exp_word) begin
      n_mis++;
      $display("FAIL sc_first_data: actual %h, required %h", d, exp_word);
    end
    do_write(32'h20, 32'h66, 4'hF, OP_SC, 1, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin
      n_mis++;
      $display("FAIL sc_second: actual bresp %b, required 00", r);
    end
    do_read(32'h20, OP_N, 1, d, r, lat);
    n_cmp++;
    if (d !== exp_word) begin
      n_mis++;
      $display("FAIL sc_second_data: actual %h, required %h", d, exp_word);
    end
  endtask

  task automatic test_lr_broken();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(32'h40, 32'h3, 4'hF, OP_N, 0, r, lat);
    do_read(32'h40, OP_LR, 0, d, r, lat);
    do_write(32'h40, 32'h7, 4'hF, OP_N, 2, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin
      n_mis++;
      $display("FAIL other_id_write: actual bresp %b, required 00", r);
    end
    do_write(32'h40, 32'h9, 4'hF, OP_SC, 0, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin
      n_mis++;
      $display("FAIL broken_sc: actual bresp %b, required 00", r);
    end
    do_read(32'h40, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'h7) begin
      n_mis++;
      $display("FAIL broken_sc_data: actual %h, required 00000007", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(32'h0, 32'h12345678, 4'hF, OP_N, 0, r, lat);
    do_write(32'hFFC, 32'h0BAD0FFC, 4'hF, OP_N, 0, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin
      n_mis++;
      $display("FAIL last_word_write: actual bresp %b, required 00", r);
    end
    do_read(32'h1000, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_mis++;
      $display("FAIL oor_read: actual %h/%b, required 00000000/10", d, r);
    end
    do_write(32'h1000, 32'hCAFEF00D, 4'hF, OP_N, 0, r, lat);
    n_cmp++;
    if (r !== 2'b10) begin
      n_mis++;
      $display("FAIL oor_write: actual bresp %b, required 10", r);
    end
    do_read(32'h0, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'h12345678) begin
      n_mis++;
      $display("FAIL oor_no_alias: actual word0 %h, required 12345678", d);
    end
    do_read(32'hFFE, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'h0BAD0FFC || r !== 2'b00) begin
      n_mis++;
      $display("FAIL last_word_read: actual %h/%b, required 0bad0ffc/00", d, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d; int lat, cyc;
    do_write(32'h60, 32'hA5A5A5A5, 4'hF, OP_N, 0, r, lat);
    do_read(32'h60, OP_LR, 0, d, r, lat);
    araddr = 32'h60; ar_op = OP_N; ar_id = 0; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 40) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    while (!rvalid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid, arready, rresp, rdata} !== 36'h0) begin
      n_mis++;
      $display("FAIL rst_in_rresp: actual rvalid %b arready %b rresp %b rdata %h, required all zero",
               rvalid, arready, rresp, rdata);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({arready, rvalid, awready, wready} !== 4'b1011) begin
      n_mis++;
      $display("FAIL rst_read_resume: actual ar/r/aw/w %b, required 1011", {arready, rvalid, awready, wready});
    end
    awaddr = 32'h60; wdata = 32'hFFFFFFFF; wstrb = 4'hF; aw_op = OP_N; aw_id = 0;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bvalid, awready, wready, bresp} !== 5'b0) begin
      n_mis++;
      $display("FAIL rst_in_commit: actual b/aw/w %b bresp %b, required 000/00", {bvalid, awready, wready}, bresp);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) cyc++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cyc !== 0) begin
      n_mis++;
      $display("FAIL rst_write_resume: actual %0d bad cycles, required 0 (bvalid 0, readys 1)", cyc);
    end
    do_write(32'h60, 32'h12, 4'hF, OP_SC, 0, r, lat);
    n_cmp++;
    if (r !== 2'b00) begin
      n_mis++;
      $display("FAIL sc_after_reset: actual bresp %b, required 00", r);
    end
    do_read(32'h60, OP_N, 0, d, r, lat);
    n_cmp++;
    if (d !== 32'hA5A5A5A5) begin
      n_mis++;
      $display("FAIL aborted_write_data: actual %h, required a5a5a5a5", d);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_lr_sc();
    test_lr_broken();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
